// File: rtl/addsub_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : addsub_arbiter
// Purpose  : Two-requester round-robin arbiter sharing one add/sub/neg/pass
//            datapath, with a valid/ready result handshake.
// Revision : 1.0 - initial release
// ============================================================================
module addsub_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [1:0]       op0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [1:0]       op1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_id,
  output logic [WIDTH-1:0] res,
  output logic             res_cout,
  output logic             res_ovf,
  output logic             busy
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_EXEC = 2'd1;
  localparam logic [1:0] c_RESP = 2'd2;

  localparam logic [1:0] c_OP_ADD  = 2'b00;
  localparam logic [1:0] c_OP_SUB  = 2'b01;
  localparam logic [1:0] c_OP_NEG  = 2'b10;
  localparam logic [1:0] c_OP_PASS = 2'b11;

  localparam logic [WIDTH-1:0] c_MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       r_state;
  logic             r_last;
  logic             r_id;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_res_valid;
  logic             r_res_id;
  logic [WIDTH-1:0] r_res;
  logic             r_res_cout;
  logic             r_res_ovf;

  logic             w_idle;
  logic             w_pick1;
  logic             w_gnt0;
  logic             w_gnt1;
  logic [WIDTH-1:0] w_x;
  logic [WIDTH-1:0] w_y;
  logic             w_cin;
  logic [WIDTH:0]   w_sum;
  logic             w_cout;
  logic             w_ovf;

  // Requester 1 wins only when alone or when requester 0 held the last grant.
  assign w_idle  = (r_state == c_IDLE);
  assign w_pick1 = req1 && (!req0 || !r_last);
  assign w_gnt1  = w_idle && w_pick1;
  assign w_gnt0  = w_idle && req0 && !w_pick1;

  always_comb begin
    w_x   = r_a;
    w_y   = '0;
    w_cin = 1'b0;
    case (r_op)
      c_OP_ADD: begin
        w_x   = r_a;
        w_y   = r_b;
        w_cin = 1'b0;
      end
      c_OP_SUB: begin
        w_x   = r_a;
        w_y   = ~r_b;
        w_cin = 1'b1;
      end
      c_OP_NEG: begin
        w_x   = ~r_a;
        w_y   = '0;
        w_cin = 1'b1;
      end
      default: begin
        w_x   = r_a;
        w_y   = '0;
        w_cin = 1'b0;
      end
    endcase
  end

  assign w_sum = {1'b0, w_x} + {1'b0, w_y} + {{WIDTH{1'b0}}, w_cin};

  always_comb begin
    w_cout = w_sum[WIDTH];
    w_ovf  = 1'b0;
    case (r_op)
      c_OP_ADD: w_ovf = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
      c_OP_SUB: w_ovf = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
      c_OP_NEG: w_ovf = (r_a == c_MIN_NEG);
      c_OP_PASS: begin
        w_cout = 1'b0;
        w_ovf  = 1'b0;
      end
      default: w_ovf = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= c_IDLE;
      r_last      <= 1'b1;
      r_id        <= 1'b0;
      r_op        <= c_OP_ADD;
      r_a         <= '0;
      r_b         <= '0;
      r_res_valid <= 1'b0;
      r_res_id    <= 1'b0;
      r_res       <= '0;
      r_res_cout  <= 1'b0;
      r_res_ovf   <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_gnt0 || w_gnt1) begin
            r_id    <= w_gnt1;
            r_last  <= w_gnt1;
            r_op    <= w_gnt1 ? op1 : op0;
            r_a     <= w_gnt1 ? a1 : a0;
            r_b     <= w_gnt1 ? b1 : b0;
            r_state <= c_EXEC;
          end
        end
        c_EXEC: begin
          r_res       <= w_sum[WIDTH-1:0];
          r_res_cout  <= w_cout;
          r_res_ovf   <= w_ovf;
          r_res_id    <= r_id;
          r_res_valid <= 1'b1;
          r_state     <= c_RESP;
        end
        c_RESP: begin
          if (r_res_valid && res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= c_IDLE;
          end
        end
        default: begin
          r_res_valid <= 1'b0;
          r_state     <= c_IDLE;
        end
      endcase
    end
  end

  assign gnt0      = w_gnt0;
  assign gnt1      = w_gnt1;
  assign res_valid = r_res_valid;
  assign res_id    = r_res_id;
  assign res       = r_res;
  assign res_cout  = r_res_cout;
  assign res_ovf   = r_res_ovf;
  assign busy      = !w_idle;

endmodule
`default_nettype wire
